// File: rtl/apb_pkg.sv
// Shared types for the APB register-file slave: FSM states, wait-counter width
// and the byte-address-to-register-index shift helper.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    localparam int WAIT_CNT_W = 4;
    typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

    function automatic int apb_idx_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// Wait-state counter: loaded at the setup edge, counts down through the access
// phase, and reports done once it reaches zero.
module apb_wait_ctr
    import apb_pkg::*;
(
    input  logic      PCLK,
    input  logic      PRESETn,
    input  logic      load,
    input  logic      clear,
    input  logic      dec,
    input  wait_cnt_t load_val,
    output logic      done
);

    wait_cnt_t cnt;

    // Clear takes priority so that an aborted transfer never leaves stale wait states behind.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/apb_regfile_slave.sv
// APB3 register-file slave with programmable wait states and PSLVERR on out-of-range index.
// Define APB_PSTRB_EN to add the PSTRB port and byte-lane write masking.
module apb_regfile_slave
    import apb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 8,
    parameter int                    WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int IDX_LSB   = apb_idx_lsb(DATA_WIDTH);
    localparam int IDX_W     = ADDR_WIDTH - IDX_LSB;
    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam logic [IDX_W:0] NUM_REGS_V = (IDX_W + 1)'(NUM_REGS);

    apb_state_e state_q, state_d, phase;

    logic                  latch, abort, complete, done;
    logic [IDX_W-1:0]      paddr_idx, idx_q;
    logic                  write_q, err_q;
    logic [DATA_WIDTH-1:0] wdata_q, rd_word;
    logic [NUM_BYTES-1:0]  strb_in, strb_q;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  unused_paddr;

    assign paddr_idx    = PADDR[ADDR_WIDTH-1:IDX_LSB];
    assign unused_paddr = ^PADDR;

`ifdef APB_PSTRB_EN
    assign strb_in = PSTRB;
`else
    assign strb_in = '1;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The register only ever holds IDLE or ACCESS: the bus setup cycle is recognised
    // while still IDLE, so that ACCESS lines up with the master's first PENABLE cycle.
    always_comb begin
        state_d = state_q;
        phase   = state_q;
        latch   = 1'b0;
        abort   = 1'b0;
        if ((state_q == IDLE) && PSEL && !PENABLE) begin
            phase = SETUP;
        end
        case (phase)
            SETUP: begin
                latch   = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (!PSEL) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (PENABLE && done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    apb_wait_ctr u_wait_ctr (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .load     (latch),
        .clear    (abort),
        .dec      ((state_q == ACCESS) && !done),
        .load_val (wait_cnt_t'(WAIT_STATES)),
        .done     (done)
    );

    // Transfer attributes are captured once so that mid-access bus changes cannot leak in.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            idx_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else if (latch) begin
            idx_q   <= paddr_idx;
            write_q <= PWRITE;
            err_q   <= ({1'b0, paddr_idx} >= NUM_REGS_V);
            wdata_q <= PWDATA;
            strb_q  <= strb_in;
        end
    end

    assign complete = (state_q == ACCESS) && PSEL && PENABLE && done;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VALUE;
            end
        end else if (complete && write_q && !err_q) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    for (int b = 0; b < NUM_BYTES; b++) begin
                        if (strb_q[b]) begin
                            regs[i][b*8 +: 8] <= wdata_q[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                rd_word = regs[i];
            end
        end
    end

    assign PREADY  = (state_q == ACCESS) && done;
    assign PSLVERR = PREADY && err_q;
    assign PRDATA  = (PREADY && !write_q && !err_q) ? rd_word : '0;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave: three instances with 0, 2 and 3 wait states.
module tb_apb_regfile_slave;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  psel_v, pready_v, pslverr_v;
    logic [31:0] prdata_a [3];

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [31:0] x_rdata;
    logic        x_err, x_err_wait;
    int          x_waits;

    always #5 pclk = ~pclk;

`ifndef APB_PSTRB_EN
    logic unused_pstrb;
    assign unused_pstrb = ^pstrb;
`endif

    // Instance 0: zero wait states, instance 1: two, instance 2: three.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb_regfile_slave #(
            .ADDR_WIDTH  (8),
            .DATA_WIDTH  (32),
            .NUM_REGS    (8),
            .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 2 : 3)),
            .RESET_VALUE (32'h0)
        ) dut (
            .PCLK    (pclk),
            .PRESETn (presetn),
            .PSEL    (psel_v[g]),
            .PENABLE (penable),
            .PWRITE  (pwrite),
            .PADDR   (paddr),
            .PWDATA  (pwdata),
`ifdef APB_PSTRB_EN
            .PSTRB   (pstrb),
`endif
            .PRDATA  (prdata_a[g]),
            .PREADY  (pready_v[g]),
            .PSLVERR (pslverr_v[g])
        );
    end

    // Called at posedge+1; returns at posedge+1 right after the completion edge with the bus
    // released, so consecutive calls produce back-to-back transfers.
    task automatic xfer(input int which, input logic wr, input logic [7:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb, input logic mid);
        x_waits    = 0;
        x_err_wait = 1'b0;
        psel_v[which] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        pstrb   = strb;
        @(posedge pclk); #1;
        penable = 1'b1;
        if (mid) begin
            paddr  = addr ^ 8'h10;
            pwdata = ~wdata;
        end
        @(negedge pclk);
        while (pready_v[which] !== 1'b1 && x_waits < 40) begin
            if (pslverr_v[which] !== 1'b0) x_err_wait = 1'b1;
            x_waits++;
            @(negedge pclk);
        end
        if (x_waits >= 40) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL xfer_timeout: dut %0d addr %h never raised PREADY, required within 40 cycles", which, addr);
        end
        x_rdata = prdata_a[which];
        x_err   = pslverr_v[which];
        @(posedge pclk); #1;
        psel_v[which] = 1'b0;
        penable = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge pclk); #1;
        end
    endtask

    task automatic test_reset();
        #3;
        for (int g = 0; g < 3; g++) begin
            n_checks++;
            if (pready_v[g] !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pready[%0d]: got %b required 0", g, pready_v[g]); end
            n_checks++;
            if (pslverr_v[g] !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pslverr[%0d]: got %b required 0", g, pslverr_v[g]); end
            n_checks++;
            if (prdata_a[g] !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_prdata[%0d]: got %h required 0", g, prdata_a[g]); end
        end
        @(negedge pclk);
        presetn = 1'b1;
        @(posedge pclk); #1;
    endtask

    task automatic test_zero_wait();
        xfer(0, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 1'b0);
        n_checks++;
        if (x_waits != 0) begin n_fail++; $display("[TB] FAIL zw_write_waits: got %0d required 0", x_waits); end
        n_checks++;
        if (x_err !== 1'b0) begin n_fail++; $display("[TB] FAIL zw_write_pslverr: got %b required 0", x_err); end
        n_checks++;
        if (x_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL zw_write_prdata: got %h required 0", x_rdata); end
        xfer(0, 1'b0, 8'h04, 32'h0, 4'hF, 1'b0);
        n_checks++;
        if (x_waits != 0) begin n_fail++; $display("[TB] FAIL zw_read_waits: got %0d required 0", x_waits); end
        n_checks++;
        if (x_rdata !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL zw_read_data: got %h required deadbeef", x_rdata); end
        n_checks++;
        if (x_err !== 1'b0) begin n_fail++; $display("[TB] FAIL zw_read_pslverr: got %b required 0", x_err); end
        idle(1);
    endtask

    task automatic test_wait_states();
        xfer(2, 1'b0, 8'h00, 32'h0, 4'hF, 1'b0);
        n_checks++;
        if (x_waits != 3) begin n_fail++; $display("[TB] FAIL ws3_read_waits: got %0d required 3", x_waits); end
        n_checks++;
        if (x_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL ws3_read_data: got %h required 0", x_rdata); end
        n_checks++;
        if (x_err !== 1'b0 || x_err_wait !== 1'b0) begin n_fail++; $display("[TB] FAIL ws3_pslverr: got %b/%b required 0/0", x_err, x_err_wait); end
        xfer(2, 1'b1, 8'h08, 32'hCAFEF00D, 4'hF, 1'b0);
        n_checks++;
        if (x_waits != 3) begin n_fail++; $display("[TB] FAIL ws3_write_waits: got %0d required 3", x_waits); end
        xfer(2, 1'b0, 8'h08, 32'h0, 4'hF, 1'b0);
        n_checks++;
        if (x_rdata !== 32'hCAFEF00D) begin n_fail++; $display("[TB] FAIL ws3_readback: got %h required cafef00d", x_rdata); end
        idle(1);
    endtask

    task automatic test_out_of_range();
        xfer(0, 1'b1, 8'h20, 32'h12345678, 4'hF, 1'b0);
        n_checks++;
        if (x_err !== 1'b1) begin n_fail++; $display("[TB] FAIL oor_write_pslverr: got %b required 1", x_err); end
        n_checks++;
        if (x_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL oor_write_prdata: got %h required 0", x_rdata); end
        xfer(0, 1'b0, 8'h20, 32'h0, 4'hF, 1'b0);
        n_checks++;
        if (x_err !== 1'b1 || x_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL oor_read: got err %b data %h required err 1 data 0", x_err, x_rdata); end
        xfer(0, 1'b1, 8'hFC, 32'hFFFFFFFF, 4'hF, 1'b0);
        n_checks++;
        if (x_err !== 1'b1) begin n_fail++; $display("[TB] FAIL oor_top_pslverr: got %b required 1", x_err); end
        xfer(0, 1'b0, 8'h00, 32'h0, 4'hF, 1'b0);
        n_checks++;
        if (x_rdata !== 32'h0 || x_err !== 1'b0) begin n_fail++; $display("[TB] FAIL oor_reg0: got data %h err %b required 0/0", x_rdata, x_err); end
        xfer(0, 1'b0, 8'h04, 32'h0, 4'hF, 1'b0);
        n_checks++;
        if (x_rdata !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL oor_reg1: got %h required deadbeef", x_rdata); end
        xfer(0, 1'b0, 8'h1C, 32'h0, 4'hF, 1'b0);
        n_checks++;
        if (x_rdata !== 32'h0 || x_err !== 1'b0) begin n_fail++; $display("[TB] FAIL oor_reg7: got data %h err %b required 0/0", x_rdata, x_err); end
        idle(1);
    endtask

    task automatic test_strobes();
        xfer(0, 1'b1, 8'h14, 32'hFFFFFFFF, 4'hF, 1'b0);
        xfer(0, 1'b1, 8'h14, 32'h00000000, 4'b0101, 1'b0);
        xfer(0, 1'b0, 8'h14, 32'h0, 4'hF, 1'b0);
`ifdef APB_PSTRB_EN
        n_checks++;
        if (x_rdata !== 32'hFF00FF00) begin n_fail++; $display("[TB] FAIL strb_0101: got %h required ff00ff00", x_rdata); end
        xfer(0, 1'b1, 8'h14, 32'h12345678, 4'b0000, 1'b0);
        n_checks++;
        if (x_err !== 1'b0 || x_waits != 0) begin n_fail++; $display("[TB] FAIL strb_zero_done: got err %b waits %0d required 0/0", x_err, x_waits); end
        xfer(0, 1'b0, 8'h14, 32'h0, 4'hF, 1'b0);
        n_checks++;
        if (x_rdata !== 32'hFF00FF00) begin n_fail++; $display("[TB] FAIL strb_zero_data: got %h required ff00ff00", x_rdata); end
`else
        n_checks++;
        if (x_rdata !== 32'h00000000) begin n_fail++; $display("[TB] FAIL full_word_write: got %h required 0", x_rdata); end
`endif
        idle(1);
    endtask

    task automatic test_back_to_back();
        xfer(0, 1'b1, 8'h0C, 32'h01020304, 4'hF, 1'b0);
        xfer(0, 1'b1, 8'h10, 32'h0A0B0C0D, 4'hF, 1'b0);
        xfer(0, 1'b0, 8'h0C, 32'h0, 4'hF, 1'b0);
        n_checks++;
        if (x_rdata !== 32'h01020304 || x_waits != 0) begin n_fail++; $display("[TB] FAIL b2b_read0: got %h waits %0d required 01020304/0", x_rdata, x_waits); end
        xfer(0, 1'b0, 8'h10, 32'h0, 4'hF, 1'b0);
        n_checks++;
        if (x_rdata !== 32'h0A0B0C0D || x_waits != 0) begin n_fail++; $display("[TB] FAIL b2b_read1: got %h waits %0d required 0a0b0c0d/0", x_rdata, x_waits); end
        idle(1);
    endtask

    task automatic test_enable_in_idle();
        psel_v[0] = 1'b1;
        penable   = 1'b1;
        pwrite    = 1'b1;
        paddr     = 8'h00;
        pwdata    = 32'hBAD0BAD0;
        pstrb     = 4'hF;
        for (int c = 0; c < 3; c++) begin
            @(negedge pclk);
            n_checks++;
            if (pready_v[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_enable_pready[%0d]: got %b required 0", c, pready_v[0]); end
        end
        @(posedge pclk); #1;
        psel_v[0] = 1'b0;
        penable   = 1'b0;
        xfer(0, 1'b0, 8'h00, 32'h0, 4'hF, 1'b0);
        n_checks++;
        if (x_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL idle_enable_nowrite: got %h required 0", x_rdata); end
        idle(1);
    endtask

    task automatic test_mid_change();
        xfer(1, 1'b1, 8'h0C, 32'h5A5A0001, 4'hF, 1'b1);
        n_checks++;
        if (x_waits != 2) begin n_fail++; $display("[TB] FAIL mid_waits: got %0d required 2", x_waits); end
        xfer(1, 1'b0, 8'h0C, 32'h0, 4'hF, 1'b0);
        n_checks++;
        if (x_rdata !== 32'h5A5A0001) begin n_fail++; $display("[TB] FAIL mid_latched: got %h required 5a5a0001", x_rdata); end
        xfer(1, 1'b0, 8'h1C, 32'h0, 4'hF, 1'b0);
        n_checks++;
        if (x_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL mid_other_reg: got %h required 0", x_rdata); end
        idle(1);
    endtask

    task automatic test_abort();
        psel_v[1] = 1'b1;
        penable   = 1'b0;
        pwrite    = 1'b1;
        paddr     = 8'h18;
        pwdata    = 32'hA5A5A5A5;
        pstrb     = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        n_checks++;
        if (pready_v[1] !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_access1: got %b required 0", pready_v[1]); end
        @(posedge pclk); #1;
        psel_v[1] = 1'b0;
        @(negedge pclk);
        n_checks++;
        if (pready_v[1] !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_access2: got %b required 0", pready_v[1]); end
        @(posedge pclk); #1;
        penable = 1'b0;
        @(negedge pclk);
        n_checks++;
        if (pready_v[1] !== 1'b0 || pslverr_v[1] !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_after: got pready %b pslverr %b required 0/0", pready_v[1], pslverr_v[1]); end
        @(posedge pclk); #1;
        xfer(1, 1'b0, 8'h18, 32'h0, 4'hF, 1'b0);
        n_checks++;
        if (x_rdata !== 32'h0 || x_waits != 2) begin n_fail++; $display("[TB] FAIL abort_nowrite: got %h waits %0d required 0/2", x_rdata, x_waits); end
        idle(1);
    endtask

    task automatic test_reset_mid_access();
        psel_v[2] = 1'b1;
        penable   = 1'b0;
        pwrite    = 1'b1;
        paddr     = 8'h08;
        pwdata    = 32'h11111111;
        pstrb     = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        n_checks++;
        if (pready_v[2] !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_wait: got %b required 0", pready_v[2]); end
        #2;
        presetn = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            n_checks++;
            if (pready_v[g] !== 1'b0 || pslverr_v[g] !== 1'b0 || prdata_a[g] !== 32'h0) begin
                n_fail++;
                $display("[TB] FAIL rst_mid_outputs[%0d]: got %b/%b/%h required 0/0/0", g, pready_v[g], pslverr_v[g], prdata_a[g]);
            end
        end
        psel_v  = 3'b000;
        penable = 1'b0;
        #1;
        presetn = 1'b1;
        @(posedge pclk); #1;
        xfer(2, 1'b0, 8'h08, 32'h0, 4'hF, 1'b0);
        n_checks++;
        if (x_rdata !== 32'h0 || x_waits != 3) begin n_fail++; $display("[TB] FAIL rst_mid_read: got %h waits %0d required 0/3", x_rdata, x_waits); end
        xfer(0, 1'b0, 8'h04, 32'h0, 4'hF, 1'b0);
        n_checks++;
        if (x_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_mid_other_regs: got %h required 0", x_rdata); end
        idle(1);
    endtask

    initial begin
        presetn = 1'b0;
        psel_v  = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 8'h00;
        pwdata  = 32'h0;
        pstrb   = 4'h0;
        $display("[TB] starting apb_regfile_slave directed tests");
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_out_of_range();
        test_strobes();
        test_back_to_back();
        test_enable_in_idle();
        test_mid_change();
        test_abort();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded 200000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
